// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types for the SPI command sequencer.
// Opcodes, FSM states and reset constants.
package spi_cmd_pkg;

    typedef enum logic [3:0] {
        OP_SET_DISP = 4'h1,
        OP_SET_DUTY = 4'h2,
        OP_MOTOR    = 4'h3,
        OP_BLANK    = 4'h4,
        OP_SOFT_RST = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ARG,
        EXEC
    } seq_state_t;

    localparam logic DISP_BLANK_RST = 1'b1;

    // True for opcodes that are followed by an operand nibble
    function automatic logic needs_arg(input logic [3:0] n);
        return (n == OP_SET_DISP) || (n == OP_SET_DUTY) ||
               (n == OP_MOTOR) || (n == OP_BLANK);
    endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Bus between SPI nibble source and the command sequencer.
// master drives nibbles, slave returns display/motor state.
interface spi_cmd_sequencer_if;
    logic [3:0] spi_data;
    logic       spi_valid;
    logic [3:0] disp_hex;
    logic       disp_blank;
    logic [3:0] duty_out;
    logic       motor_en;
    logic       cmd_ack;
    logic       cmd_err;

    modport master (
        output spi_data, spi_valid,
        input  disp_hex, disp_blank, duty_out, motor_en, cmd_ack, cmd_err
    );

    modport slave (
        input  spi_data, spi_valid,
        output disp_hex, disp_blank, duty_out, motor_en, cmd_ack, cmd_err
    );
endinterface

// File: rtl/spi_cmd_sequencer_ramp.sv
// Rate-limited PWM duty ramp: one +/-1 step per RAMP_DIV cycles.
// Disabled ramp holds duty at zero; target is owned by the caller.
module duty_ramp #(
    parameter int RAMP_DIV = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] tgt,
    output logic [3:0] duty
);
    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [CW-1:0] cnt;

    // Prescaler restarts at target; each wrap moves duty one step toward tgt
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            duty <= 4'd0;
            cnt  <= '0;
        end else if (duty == tgt) begin
            cnt <= '0;
        end else if (cnt == CW'(RAMP_DIV - 1)) begin
            cnt  <= '0;
            duty <= (duty < tgt) ? duty + 4'd1 : duty - 4'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_cmd_sequencer.sv
// Frames SPI nibbles into opcode/operand commands and drives
// display and motor configuration registers.
module spi_cmd_sequencer
    import spi_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int RAMP_DIV       = 500_000
) (
    input logic           clk,
    input logic           reset,
    spi_cmd_sequencer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    seq_state_t  state;
    opcode_t     op;
    logic [3:0]  arg;
    logic [TW-1:0] timer;
    logic        drop_pend;
    logic [3:0]  disp_hex;
    logic        disp_blank;
    logic [3:0]  duty_tgt;
    logic        motor_en;
    logic        cmd_ack;
    logic        cmd_err;
    logic [3:0]  duty;
    logic        ramp_rst;

    // Soft reset clears the ramp on the same edge as the config registers
    always_comb begin
        ramp_rst = reset;
        if (state == EXEC && op == OP_SOFT_RST) ramp_rst = 1'b0;
    end

    // Frame FSM, timeout counter and config registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            op         <= OP_SET_DISP;
            arg        <= 4'd0;
            timer      <= '0;
            drop_pend  <= 1'b0;
            disp_hex   <= 4'd0;
            disp_blank <= DISP_BLANK_RST;
            duty_tgt   <= 4'd0;
            motor_en   <= 1'b0;
            cmd_ack    <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_ack   <= 1'b0;
            cmd_err   <= 1'b0;
            drop_pend <= 1'b0;
            case (state)
                IDLE: begin
                    // a nibble dropped in EXEC reports here, clear of cmd_ack
                    cmd_err <= drop_pend;
                    if (bus.spi_valid) begin
                        if (needs_arg(bus.spi_data)) begin
                            op    <= opcode_t'(bus.spi_data);
                            timer <= '0;
                            state <= WAIT_ARG;
                        end else if (bus.spi_data == OP_SOFT_RST) begin
                            op    <= OP_SOFT_RST;
                            state <= EXEC;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                WAIT_ARG: begin
                    if (bus.spi_valid) begin
                        arg   <= bus.spi_data;
                        state <= EXEC;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        cmd_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                EXEC: begin
                    cmd_ack   <= 1'b1;
                    drop_pend <= bus.spi_valid;
                    state     <= IDLE;
                    case (op)
                        OP_SET_DISP: begin
                            disp_hex   <= arg;
                            disp_blank <= 1'b0;
                        end
                        OP_SET_DUTY: duty_tgt   <= arg;
                        OP_MOTOR:    motor_en   <= arg[0];
                        OP_BLANK:    disp_blank <= arg[0];
                        OP_SOFT_RST: begin
                            disp_hex   <= 4'd0;
                            disp_blank <= DISP_BLANK_RST;
                            duty_tgt   <= 4'd0;
                            motor_en   <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    duty_ramp #(.RAMP_DIV(RAMP_DIV)) u_ramp (
        .clk   (clk),
        .reset (ramp_rst),
        .en    (motor_en),
        .tgt   (duty_tgt),
        .duty  (duty)
    );

    assign bus.disp_hex   = disp_hex;
    assign bus.disp_blank = disp_blank;
    assign bus.duty_out   = duty;
    assign bus.motor_en   = motor_en;
    assign bus.cmd_ack    = cmd_ack;
    assign bus.cmd_err    = cmd_err;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer (TIMEOUT_CYCLES=20, RAMP_DIV=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_spi_cmd_sequencer;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;

    spi_cmd_sequencer_if bus ();

    spi_cmd_sequencer #(.TIMEOUT_CYCLES(20), .RAMP_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one nibble for exactly one rising edge
    task automatic strobe(input logic [3:0] n);
        bus.spi_data  = n;
        bus.spi_valid = 1'b1;
        @(negedge clk);
        bus.spi_valid = 1'b0;
        bus.spi_data  = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        bus.spi_valid = 1'b0;
        bus.spi_data  = 4'd0;
        idle(3);
        reset = 1'b1;
        idle(2);

        // 1: reset state
        chk("rst_blank", 8'(bus.disp_blank), 8'd1);
        chk("rst_hex",   8'(bus.disp_hex),   8'd0);
        chk("rst_duty",  8'(bus.duty_out),   8'd0);
        chk("rst_motor", 8'(bus.motor_en),   8'd0);
        chk("rst_ack",   8'(bus.cmd_ack),    8'd0);
        chk("rst_err",   8'(bus.cmd_err),    8'd0);

        // 2: SET_DISP 0xA, operand 3 cycles after opcode
        strobe(4'h1);
        idle(2);
        strobe(4'hA);
        chk("disp_ack_early", 8'(bus.cmd_ack), 8'd0);
        idle(1);
        chk("disp_ack",   8'(bus.cmd_ack),    8'd1);
        chk("disp_hex",   8'(bus.disp_hex),   8'hA);
        chk("disp_blank", 8'(bus.disp_blank), 8'd0);
        chk("disp_err",   8'(bus.cmd_err),    8'd0);
        idle(1);
        chk("disp_ack_off", 8'(bus.cmd_ack), 8'd0);

        // BLANK on and off, hex retained
        strobe(4'h4); strobe(4'h1); idle(1);
        chk("blank_on",  8'(bus.disp_blank), 8'd1);
        chk("blank_hex", 8'(bus.disp_hex),   8'hA);
        strobe(4'h4); strobe(4'h0); idle(1);
        chk("blank_off", 8'(bus.disp_blank), 8'd0);

        // 3: motor on, ramp 0 -> 6, reverse to 2 at duty 4
        strobe(4'h3); strobe(4'h1); idle(1);
        chk("motor_on",  8'(bus.motor_en), 8'd1);
        chk("duty_idle", 8'(bus.duty_out), 8'd0);
        strobe(4'h2); strobe(4'h6); idle(1);
        chk("duty_ack", 8'(bus.cmd_ack), 8'd1);
        idle(3);
        chk("ramp_t3",  8'(bus.duty_out), 8'd0);
        idle(1);
        chk("ramp_t4",  8'(bus.duty_out), 8'd1);
        idle(4);
        chk("ramp_t8",  8'(bus.duty_out), 8'd2);
        idle(4);
        chk("ramp_t12", 8'(bus.duty_out), 8'd3);
        idle(4);
        chk("ramp_t16", 8'(bus.duty_out), 8'd4);
        strobe(4'h2); strobe(4'h2);
        chk("ramp_t18", 8'(bus.duty_out), 8'd4);
        idle(1);
        chk("rev_ack",  8'(bus.cmd_ack),  8'd1);
        chk("ramp_t19", 8'(bus.duty_out), 8'd4);
        idle(1);
        chk("ramp_t20", 8'(bus.duty_out), 8'd3);
        idle(4);
        chk("ramp_t24", 8'(bus.duty_out), 8'd2);
        idle(8);
        chk("ramp_hold", 8'(bus.duty_out), 8'd2);

        // 4: timeout after 20 cycles without operand
        strobe(4'h2);
        idle(19);
        chk("to_early", 8'(bus.cmd_err), 8'd0);
        idle(1);
        chk("to_err",   8'(bus.cmd_err), 8'd1);
        chk("to_ack",   8'(bus.cmd_ack), 8'd0);
        idle(1);
        chk("to_err_off", 8'(bus.cmd_err),  8'd0);
        chk("to_duty",    8'(bus.duty_out), 8'd2);
        strobe(4'h1); strobe(4'h3); idle(1);
        chk("to_next_hex", 8'(bus.disp_hex), 8'd3);
        chk("to_next_ack", 8'(bus.cmd_ack),  8'd1);

        // 5: illegal opcode, then nibble dropped during EXEC
        idle(1);
        strobe(4'h7);
        chk("ill_err", 8'(bus.cmd_err),  8'd1);
        chk("ill_ack", 8'(bus.cmd_ack),  8'd0);
        chk("ill_hex", 8'(bus.disp_hex), 8'd3);
        idle(1);
        chk("ill_err_off", 8'(bus.cmd_err), 8'd0);
        strobe(4'h1); strobe(4'h5); strobe(4'h9);
        chk("drop_ack",  8'(bus.cmd_ack),  8'd1);
        chk("drop_noerr", 8'(bus.cmd_err), 8'd0);
        chk("drop_hex",  8'(bus.disp_hex), 8'd5);
        idle(1);
        chk("drop_err",   8'(bus.cmd_err), 8'd1);
        chk("drop_ack_off", 8'(bus.cmd_ack), 8'd0);
        idle(1);
        chk("drop_err_off", 8'(bus.cmd_err), 8'd0);
        strobe(4'h1); strobe(4'h6); idle(1);
        chk("drop_next_hex", 8'(bus.disp_hex), 8'd6);

        // 6: soft reset while ramping at 5
        strobe(4'h2); strobe(4'h9); idle(1);
        idle(12);
        chk("sr_pre_duty", 8'(bus.duty_out), 8'd5);
        strobe(4'hF); idle(1);
        chk("sr_ack",   8'(bus.cmd_ack),    8'd1);
        chk("sr_err",   8'(bus.cmd_err),    8'd0);
        chk("sr_duty",  8'(bus.duty_out),   8'd0);
        chk("sr_motor", 8'(bus.motor_en),   8'd0);
        chk("sr_blank", 8'(bus.disp_blank), 8'd1);
        chk("sr_hex",   8'(bus.disp_hex),   8'd0);
        strobe(4'h3); strobe(4'h1); idle(1);
        idle(8);
        chk("sr_tgt_clr", 8'(bus.duty_out), 8'd0);

        // motor off forces duty to 0, target kept for re-enable
        strobe(4'h2); strobe(4'h3); idle(1);
        idle(12);
        chk("off_pre", 8'(bus.duty_out), 8'd3);
        strobe(4'h3); strobe(4'h0); idle(1);
        chk("off_motor", 8'(bus.motor_en), 8'd0);
        chk("off_same",  8'(bus.duty_out), 8'd3);
        idle(1);
        chk("off_duty",  8'(bus.duty_out), 8'd0);
        strobe(4'h3); strobe(4'h1); idle(1);
        chk("reen_duty0", 8'(bus.duty_out), 8'd0);
        idle(4);
        chk("reen_duty1", 8'(bus.duty_out), 8'd1);

        // hard reset while in WAIT_ARG
        strobe(4'h1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        chk("hr_ack",   8'(bus.cmd_ack),    8'd0);
        chk("hr_err",   8'(bus.cmd_err),    8'd0);
        chk("hr_blank", 8'(bus.disp_blank), 8'd1);
        chk("hr_motor", 8'(bus.motor_en),   8'd0);
        chk("hr_duty",  8'(bus.duty_out),   8'd0);
        idle(1);
        strobe(4'h5);
        chk("hr_idle_err", 8'(bus.cmd_err), 8'd1);
        chk("hr_idle_ack", 8'(bus.cmd_ack), 8'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
